// File: rtl/sram_responder.sv
// sram_responder: device side of the core's SRAM bus. A 64-bit-wide word
// array with programmable read and write wait states, so the MEM stage
// sees realistic sram_ready/freeze behaviour. Every change of the
// (SRAM_ADDR, SRAM_WE_N) pair starts a new access and cancels the old one.
module sram_responder #(
   parameter int    ADDR_W        = 17,
   parameter int    DEPTH         = 131072,
   parameter int    READ_LATENCY  = 4,
   parameter int    WRITE_LATENCY = 4,
   parameter string INIT_FILE     = ""
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [63:0]       SRAM_DQ,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   input  logic              SRAM_WE_N,
   output logic              dq_valid,
   output logic              wr_done
);

   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_WAIT,
      S_READ_VALID,
      S_WRITE_WAIT,
      S_WRITE_HOLD
   } state_e;

   state_e            state_q, state_d;
   // Edges still to wait before the load/commit edge of the current access.
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic              cap_we_n_q, cap_we_n_d;
   logic              cap_vld_q, cap_vld_d;
   logic              dq_valid_q, dq_valid_d;
   logic              wr_done_q, wr_done_d;
   logic [63:0]       rd_data_q;

   logic              pair_change;
   logic              in_range;
   logic              load_en;
   logic              commit;
   logic              wr_en;
   logic [IDX_W-1:0]  idx;

   logic [63:0]       mem [DEPTH];

   assign idx         = SRAM_ADDR[IDX_W-1:0];
   assign in_range    = (32'(SRAM_ADDR) < 32'(DEPTH));
   assign pair_change = !cap_vld_q || (SRAM_ADDR != cap_addr_q) || (SRAM_WE_N != cap_we_n_q);
   // Out-of-range writes still complete the handshake but never touch the array.
   assign wr_en       = rst && commit && in_range;

   // Tristate is purely combinational so the bus is released the moment the
   // core turns it around for a write or reset is asserted.
   assign SRAM_DQ  = (SRAM_WE_N && rst) ? rd_data_q : 64'bz;
   assign dq_valid = dq_valid_q;
   assign wr_done  = wr_done_q;

   // Next-state logic: start/abort on pair change, otherwise count down the wait states.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_addr_d = cap_addr_q;
      cap_we_n_d = cap_we_n_q;
      cap_vld_d  = cap_vld_q;
      dq_valid_d = dq_valid_q;
      wr_done_d  = 1'b0;
      load_en    = 1'b0;
      commit     = 1'b0;

      if (pair_change) begin
         cap_addr_d = SRAM_ADDR;
         cap_we_n_d = SRAM_WE_N;
         cap_vld_d  = 1'b1;
         dq_valid_d = 1'b0;
         if (SRAM_WE_N) begin
            if (READ_LATENCY == 1) begin
               load_en    = 1'b1;
               dq_valid_d = 1'b1;
               state_d    = S_READ_VALID;
            end else begin
               cnt_d   = CNT_W'(READ_LATENCY - 2);
               state_d = S_READ_WAIT;
            end
         end else begin
            if (WRITE_LATENCY == 1) begin
               commit    = 1'b1;
               wr_done_d = 1'b1;
               state_d   = S_WRITE_HOLD;
            end else begin
               cnt_d   = CNT_W'(WRITE_LATENCY - 2);
               state_d = S_WRITE_WAIT;
            end
         end
      end else begin
         unique case (state_q)
            S_READ_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  load_en    = 1'b1;
                  dq_valid_d = 1'b1;
                  state_d    = S_READ_VALID;
               end
            end
            S_WRITE_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  commit    = 1'b1;
                  wr_done_d = 1'b1;
                  state_d   = S_WRITE_HOLD;
               end
            end
            default: ;
         endcase
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every register sees pre-edge values.
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cap_addr_q <= '0;
         cap_we_n_q <= 1'b1;
         cap_vld_q  <= 1'b0;
         dq_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_addr_q <= cap_addr_d;
         cap_we_n_q <= cap_we_n_d;
         cap_vld_q  <= cap_vld_d;
         dq_valid_q <= dq_valid_d;
         wr_done_q  <= wr_done_d;
      end
   end

   // Registered read port; out-of-range words read as zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else if (load_en) begin
         rd_data_q <= in_range ? mem[idx] : 64'h0;
      end
   end

   // Array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; contents survive rst like a real SRAM.
      if (wr_en) begin
         mem[idx] <= SRAM_DQ;
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: a 4/4-latency full-depth instance and a
// 1/1-latency 1024-word instance see the same bus stimulus. The reference
// model counts how many consecutive edges the current (addr, we_n) pair has
// been held and applies the latency rules to that count directly.
module tb_sram_responder;

   logic        clk;
   logic        rst;
   logic [16:0] addr;
   logic        we_n;
   logic [63:0] tb_dq;
   logic        tb_drive;
   wire  [63:0] dq_a;
   wire  [63:0] dq_f;
   logic        dq_valid_a, wr_done_a;
   logic        dq_valid_f, wr_done_f;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   // Reference model state.
   logic [63:0] mem_a [int];
   logic [63:0] mem_f [int];
   int          held;
   logic        pair_ok;
   logic [16:0] cur_a;
   logic        cur_w;

   // The bench drives the bus for writes and throughout reset; any DUT drive
   // at those times corrupts what the bus carries.
   assign tb_drive = !we_n || !rst;
   assign dq_a = tb_drive ? tb_dq : 64'bz;
   assign dq_f = tb_drive ? tb_dq : 64'bz;

   sram_responder u_a (
      .clk(clk), .rst(rst), .SRAM_DQ(dq_a), .SRAM_ADDR(addr),
      .SRAM_WE_N(we_n), .dq_valid(dq_valid_a), .wr_done(wr_done_a)
   );

   sram_responder #(
      .READ_LATENCY(1), .WRITE_LATENCY(1), .DEPTH(1024)
   ) u_f (
      .clk(clk), .rst(rst), .SRAM_DQ(dq_f), .SRAM_ADDR(addr),
      .SRAM_WE_N(we_n), .dq_valid(dq_valid_f), .wr_done(wr_done_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // One clock edge with the given bus inputs, then compare against the model.
   task automatic step(input logic r, input logic [16:0] a, input logic w, input logic [63:0] d);
      logic exp_v_a, exp_w_a, exp_v_f, exp_w_f;
      rst = r; addr = a; we_n = w; tb_dq = d;
      @(posedge clk);
      if (!r) begin
         pair_ok = 1'b0;
         held    = 0;
      end else begin
         if (pair_ok && a == cur_a && w == cur_w) begin
            held++;
         end else begin
            held = 1; cur_a = a; cur_w = w; pair_ok = 1'b1;
         end
         if (!w && held == 4) mem_a[int'(a)] = d;
         if (!w && held == 1 && a < 17'd1024) mem_f[int'(a)] = d;
      end
      #1;
      exp_v_a = r && w && held >= 4;
      exp_w_a = r && !w && held == 4;
      exp_v_f = r && w && held >= 1;
      exp_w_f = r && !w && held == 1;
      check("a.dq_valid", {63'd0, dq_valid_a}, {63'd0, exp_v_a});
      check("a.wr_done",  {63'd0, wr_done_a},  {63'd0, exp_w_a});
      check("f.dq_valid", {63'd0, dq_valid_f}, {63'd0, exp_v_f});
      check("f.wr_done",  {63'd0, wr_done_f},  {63'd0, exp_w_f});
      if (!w || !r) begin
         check("a.bus_released", dq_a, d);
         check("f.bus_released", dq_f, d);
      end else begin
         if (exp_v_a && mem_a.exists(int'(a))) check("a.rdata", dq_a, mem_a[int'(a)]);
         if (exp_v_f) begin
            if (a >= 17'd1024)              check("f.rdata_oor", dq_f, 64'h0);
            else if (mem_f.exists(int'(a))) check("f.rdata", dq_f, mem_f[int'(a)]);
         end
      end
   endtask

   logic [16:0] ra;
   logic        rw;
   logic [63:0] rd;
   int          hold;

   initial begin
      held = 0; pair_ok = 1'b0; cur_a = '0; cur_w = 1'b1;
      rst = 1'b0; addr = '0; we_n = 1'b1; tb_dq = '0;

      // T1: reset held three cycles with WE_N=1.
      for (int i = 0; i < 3; i++) step(1'b0, 17'h0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);

      // T2: write then read back address 0x10.
      for (int i = 0; i < 4; i++) step(1'b1, 17'h10, 1'b0, 64'hDEADBEEF01234567);
      for (int i = 0; i < 5; i++) step(1'b1, 17'h10, 1'b1, 64'h0);

      // T3: known value at 0x20, aborted write of 1, then read back.
      for (int i = 0; i < 4; i++) step(1'b1, 17'h20, 1'b0, 64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 2; i++) step(1'b1, 17'h20, 1'b0, 64'h1);
      step(1'b1, 17'h21, 1'b0, 64'h2);
      for (int i = 0; i < 4; i++) step(1'b1, 17'h20, 1'b1, 64'h0);

      // T4: read of 0x10 retargeted to 0x30 after two edges.
      for (int i = 0; i < 4; i++) step(1'b1, 17'h30, 1'b0, 64'hCAFE_F00D_1234_5678);
      for (int i = 0; i < 2; i++) step(1'b1, 17'h10, 1'b1, 64'h0);
      for (int i = 0; i < 5; i++) step(1'b1, 17'h30, 1'b1, 64'h0);

      // T5: reset at the second edge of a read, and reset mid-write.
      step(1'b1, 17'h10, 1'b1, 64'h0);
      step(1'b0, 17'h10, 1'b1, 64'h5555_AAAA_5555_AAAA);
      for (int i = 0; i < 4; i++) step(1'b1, 17'h10, 1'b1, 64'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 17'h40, 1'b0, 64'h1111_2222_3333_4444);
      for (int i = 0; i < 2; i++) step(1'b1, 17'h40, 1'b0, 64'h9999_8888_7777_6666);
      step(1'b0, 17'h40, 1'b0, 64'h9999_8888_7777_6666);
      for (int i = 0; i < 4; i++) step(1'b1, 17'h40, 1'b1, 64'h0);

      // T6: out-of-range on the 1024-word instance; 2000 aliases 0x3D0 in its low bits.
      for (int i = 0; i < 4; i++) step(1'b1, 17'h3D0, 1'b0, 64'hFEED_FACE_0000_0001);
      for (int i = 0; i < 4; i++) step(1'b1, 17'd2000, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
      for (int i = 0; i < 4; i++) step(1'b1, 17'h3D0, 1'b1, 64'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 17'd2000, 1'b1, 64'h0);

      // Randomized accesses with random hold times and occasional resets.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0:       ra = 17'h10;
            1:       ra = 17'h20;
            2:       ra = 17'h30;
            3:       ra = 17'h3D0;
            4:       ra = 17'd2000;
            default: ra = 17'($urandom_range(0, 2047));
         endcase
         rw   = 1'($urandom_range(0, 1));
         rd   = {$urandom, $urandom};
         hold = $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) step(1'b0, ra, rw, {$urandom, $urandom});
         for (int h = 0; h < hold; h++) step(1'b1, ra, rw, rd);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
